// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: entry password check, lot occupancy tracking, gate LEDs
// and two active-low 7-segment status digits ({g,f,e,d,c,b,a}).
// Optional feature macro: LOCKOUT_EN adds a wrong-try counter and a timed
// LOCKED state; without it WRONG_PASS retries indefinitely and locked is 0.
module parking_gate_ctrl #(
    parameter int unsigned     PW_W      = 2,
    parameter logic [PW_W-1:0] PASS_1    = PW_W'(2'b01),
    parameter logic [PW_W-1:0] PASS_2    = PW_W'(2'b10),
    parameter int unsigned     CAPACITY  = 8,
    parameter int unsigned     CNT_W     = 4,
    parameter int unsigned     WAIT_CYC  = 4,
    parameter int unsigned     MAX_TRIES = 3,
    parameter int unsigned     LOCK_CYC  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sensor_entrance,
    input  logic             sensor_exit,
    input  logic             sensor_depart,
    input  logic [PW_W-1:0]  password_1,
    input  logic [PW_W-1:0]  password_2,
    output logic             GREEN_LED,
    output logic             RED_LED,
    output logic [6:0]       HEX_1,
    output logic [6:0]       HEX_2,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             locked
);

    // Shared cycle counter must cover both the password wait and the lockout
    localparam int unsigned CYC_MAX = (WAIT_CYC > LOCK_CYC) ? WAIT_CYC : LOCK_CYC;
    localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

    // Seven-segment glyphs, active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] HEX_BLANK = 7'h7F;
    localparam logic [6:0] HEX_E     = 7'b0000110;
    localparam logic [6:0] HEX_N     = 7'b0101011;
    localparam logic [6:0] HEX_G     = 7'b1000010;
    localparam logic [6:0] HEX_O     = 7'b1000000;
    localparam logic [6:0] HEX_S     = 7'b0010010;
    localparam logic [6:0] HEX_P     = 7'b0001100;
    localparam logic [6:0] HEX_F     = 7'b0001110;
    localparam logic [6:0] HEX_U     = 7'b1000001;
    localparam logic [6:0] HEX_L     = 7'b1000111;
    localparam logic [6:0] HEX_LO    = 7'b0100011;

    // Reject configurations the occupancy and timing logic cannot represent
    if (CAPACITY < 1 || WAIT_CYC < 1 || LOCK_CYC < 1 || MAX_TRIES < 1 ||
        (2 ** CNT_W) <= CAPACITY) begin : g_cfg_err
        $error("parking_gate_ctrl: invalid parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_WAIT_PASSWORD = 3'd1,
        S_WRONG_PASS    = 3'd2,
        S_RIGHT_PASS    = 3'd3,
        S_STOP          = 3'd4,
        S_FULL          = 3'd5,
        S_LOCKED        = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cnt_q, cnt_d;
    logic               blink_q, blink_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic               depart_q;

    logic               pass_ok_c;
    logic               full_c;
    logic               wait_last_c;
    logic               occ_inc_c;
    logic               occ_dec_c;

`ifdef LOCKOUT_EN
    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

    logic [TRY_W-1:0]   tries_q, tries_d;
    logic               lock_last_c;
    logic               last_try_c;

    assign lock_last_c = (cnt_q == CYC_W'(LOCK_CYC - 1));
    assign last_try_c  = (tries_q == TRY_W'(MAX_TRIES - 1));
`endif

    assign pass_ok_c   = (password_1 == PASS_1) && (password_2 == PASS_2);
    assign full_c      = (occ_q == CNT_W'(CAPACITY));
    assign wait_last_c = (cnt_q == CYC_W'(WAIT_CYC - 1));
    assign occ_inc_c   = (state_q == S_RIGHT_PASS) && sensor_exit;
    assign occ_dec_c   = sensor_depart && !depart_q;

    assign occupancy = occ_q;
    assign full      = full_c;

    // State, counters, blink and occupancy registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            blink_q  <= 1'b0;
            occ_q    <= '0;
            depart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            blink_q  <= blink_d;
            occ_q    <= occ_d;
            depart_q <= sensor_depart;
        end
    end

`ifdef LOCKOUT_EN
    // Wrong-attempt counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tries_q <= '0;
        end else begin
            tries_q <= tries_d;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sensor_entrance) begin
                    state_d = full_c ? S_FULL : S_WAIT_PASSWORD;
                end
            end
            S_FULL: begin
                if (!sensor_entrance || !full_c) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_PASSWORD: begin
                if (wait_last_c) begin
                    if (pass_ok_c) begin
                        state_d = S_RIGHT_PASS;
                    end else begin
`ifdef LOCKOUT_EN
                        state_d = last_try_c ? S_LOCKED : S_WRONG_PASS;
`else
                        state_d = S_WRONG_PASS;
`endif
                    end
                end
            end
            S_WRONG_PASS: begin
                if (wait_last_c) begin
                    state_d = S_WAIT_PASSWORD;
                end
            end
            S_RIGHT_PASS: begin
                if (sensor_exit) begin
                    state_d = sensor_entrance ? S_STOP : S_IDLE;
                end
            end
            S_STOP: begin
                if (pass_ok_c) begin
                    state_d = S_RIGHT_PASS;
                end
            end
`ifdef LOCKOUT_EN
            S_LOCKED: begin
                if (lock_last_c) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Dwell counter: runs in timed states, clears on every state change
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q &&
            (state_q == S_WAIT_PASSWORD || state_q == S_WRONG_PASS ||
             state_q == S_LOCKED)) begin
            cnt_d = cnt_q + CYC_W'(1);
        end
    end

    // Blink flop toggles only while showing an error that needs attention
    always_comb begin
        blink_d = 1'b0;
        if (state_q == S_WRONG_PASS || state_q == S_STOP) begin
            blink_d = !blink_q;
        end
    end

    // Saturating occupancy; simultaneous admit and departure cancel out
    always_comb begin
        occ_d = occ_q;
        case ({occ_inc_c, occ_dec_c})
            2'b10: begin
                if (occ_q != CNT_W'(CAPACITY)) begin
                    occ_d = occ_q + CNT_W'(1);
                end
            end
            2'b01: begin
                if (occ_q != '0) begin
                    occ_d = occ_q - CNT_W'(1);
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
    end

`ifdef LOCKOUT_EN
    // Try counter: bump per wrong verdict, clear on admission or lockout end
    always_comb begin
        tries_d = tries_q;
        if (state_q == S_WAIT_PASSWORD && state_d == S_WRONG_PASS) begin
            tries_d = tries_q + TRY_W'(1);
        end
        if (state_d == S_RIGHT_PASS && state_q != S_RIGHT_PASS) begin
            tries_d = '0;
        end
        if (state_q == S_LOCKED && state_d != S_LOCKED) begin
            tries_d = '0;
        end
    end

    assign locked = (state_q == S_LOCKED);
`else
    assign locked = 1'b0;
`endif

    // Moore output decode of the state register and blink flop
    always_comb begin
        GREEN_LED = 1'b0;
        RED_LED   = 1'b0;
        HEX_1     = HEX_BLANK;
        HEX_2     = HEX_BLANK;
        case (state_q)
            S_WAIT_PASSWORD: begin
                RED_LED = 1'b1;
                HEX_1   = HEX_E;
                HEX_2   = HEX_N;
            end
            S_WRONG_PASS: begin
                RED_LED = blink_q;
                HEX_1   = HEX_E;
                HEX_2   = HEX_E;
            end
            S_RIGHT_PASS: begin
                GREEN_LED = 1'b1;
                HEX_1     = HEX_G;
                HEX_2     = HEX_O;
            end
            S_STOP: begin
                RED_LED = blink_q;
                HEX_1   = HEX_S;
                HEX_2   = HEX_P;
            end
            S_FULL: begin
                RED_LED = 1'b1;
                HEX_1   = HEX_F;
                HEX_2   = HEX_U;
            end
            S_LOCKED: begin
                RED_LED = 1'b1;
                HEX_1   = HEX_L;
                HEX_2   = HEX_LO;
            end
            default: begin
                GREEN_LED = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl (CAPACITY=3). Stimulus pushes the
// expected output snapshot; a monitor on the falling edge pops and compares.
// Lockout sequence runs only when LOCKOUT_EN is defined.
module tb_parking_gate_ctrl;

    localparam int unsigned CAP = 3;

    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] GE = 7'b0000110;
    localparam logic [6:0] GN = 7'b0101011;
    localparam logic [6:0] GG = 7'b1000010;
    localparam logic [6:0] GO = 7'b1000000;
    localparam logic [6:0] GS = 7'b0010010;
    localparam logic [6:0] GP = 7'b0001100;
    localparam logic [6:0] GF = 7'b0001110;
    localparam logic [6:0] GU = 7'b1000001;
    localparam logic [6:0] GL = 7'b1000111;
    localparam logic [6:0] GLO = 7'b0100011;

    logic       clk;
    logic       rst_n;
    logic       ent, ex, dep;
    logic [1:0] p1, p2;
    logic       green, red, full_o, locked_o;
    logic [6:0] hex1, hex2;
    logic [3:0] occ;

    parking_gate_ctrl #(
        .CAPACITY (CAP)
    ) dut (
        .clk             (clk),
        .reset_n         (rst_n),
        .sensor_entrance (ent),
        .sensor_exit     (ex),
        .sensor_depart   (dep),
        .password_1      (p1),
        .password_2      (p2),
        .GREEN_LED       (green),
        .RED_LED         (red),
        .HEX_1           (hex1),
        .HEX_2           (hex2),
        .occupancy       (occ),
        .full            (full_o),
        .locked          (locked_o)
    );

    // {green, red, hex1, hex2, occupancy, full, locked}
    typedef logic [21:0] snap_t;

    snap_t exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compare every queued expectation away from the rising edge
    always @(negedge clk) begin
        snap_t e;
        snap_t a;
        string nm;
        while (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {green, red, hex1, hex2, occ, full_o, locked_o};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got g=%b r=%b h1=%b h2=%b occ=%0d full=%b lk=%b, expected g=%b r=%b h1=%b h2=%b occ=%0d full=%b lk=%b",
                         nm, a[21], a[20], a[19:13], a[12:6], a[5:2], a[1], a[0],
                         e[21], e[20], e[19:13], e[12:6], e[5:2], e[1], e[0]);
            end
        end
    end

    task automatic chk(input string nm, input logic g, input logic r,
                       input logic [6:0] h1, input logic [6:0] h2,
                       input int o, input logic lk);
        logic f;
        f = (o == int'(CAP));
        exp_q.push_back({g, r, h1, h2, 4'(o), f, lk});
        name_q.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pw_ok();
        p1 = 2'b01;
        p2 = 2'b10;
    endtask

    task automatic pw_bad();
        p1 = 2'b00;
        p2 = 2'b00;
    endtask

    // Four WAIT_PASSWORD cycles followed by the verdict cycle into RIGHT_PASS
    task automatic wait_then_right(input string nm, input int o);
        for (int i = 0; i < 4; i++) begin
            step();
            chk({nm, "_wait"}, 1'b0, 1'b1, GE, GN, o, 1'b0);
        end
        step();
        chk({nm, "_right"}, 1'b1, 1'b0, GG, GO, o, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        ent = 1'b0; ex = 1'b0; dep = 1'b0;
        p1 = 2'b00; p2 = 2'b00;

        // Reset state
        for (int i = 0; i < 5; i++) begin
            step();
            chk("reset", 1'b0, 1'b0, BL, BL, 0, 1'b0);
        end
        rst_n = 1'b1;

        // T1: correct password, admit one car
        ent = 1'b1;
        pw_ok();
        wait_then_right("t1", 0);
        step();
        chk("t1_hold", 1'b1, 1'b0, GG, GO, 0, 1'b0);
        ent = 1'b0; ex = 1'b1;
        step();
        chk("t1_exit_idle", 1'b0, 1'b0, BL, BL, 1, 1'b0);
        ex = 1'b0;

        // T2: wrong password, blink, then fix password
        ent = 1'b1;
        pw_bad();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_wait", 1'b0, 1'b1, GE, GN, 1, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_wrong", 1'b0, 1'(i % 2), GE, GE, 1, 1'b0);
            if (i == 0) pw_ok();
        end
        wait_then_right("t2", 1);

        // T4: tailgater -> STOP, blinking, then password clears it
        ex = 1'b1;
        pw_bad();
        step();
        chk("t4_stop0", 1'b0, 1'b0, GS, GP, 2, 1'b0);
        ex = 1'b0;
        step();
        chk("t4_stop1", 1'b0, 1'b1, GS, GP, 2, 1'b0);
        step();
        chk("t4_stop2", 1'b0, 1'b0, GS, GP, 2, 1'b0);
        pw_ok();
        step();
        chk("t4_right", 1'b1, 1'b0, GG, GO, 2, 1'b0);
        ent = 1'b0; ex = 1'b1;
        step();
        chk("t4_idle_full", 1'b0, 1'b0, BL, BL, 3, 1'b0);
        ex = 1'b0;

        // T3: lot full -> FULL_S, departure frees a space
        ent = 1'b1;
        step();
        chk("t3_full_s", 1'b0, 1'b1, GF, GU, 3, 1'b0);
        step();
        chk("t3_full_hold", 1'b0, 1'b1, GF, GU, 3, 1'b0);
        dep = 1'b1;
        step();
        chk("t3_depart", 1'b0, 1'b1, GF, GU, 2, 1'b0);
        ent = 1'b0; dep = 1'b0;
        step();
        chk("t3_idle", 1'b0, 1'b0, BL, BL, 2, 1'b0);
        ent = 1'b1;
        wait_then_right("t3", 2);
        ent = 1'b0; ex = 1'b1; dep = 1'b1;
        step();
        chk("t3_exit_and_depart", 1'b0, 1'b0, BL, BL, 2, 1'b0);
        ex = 1'b0; dep = 1'b0;

        // Reach RIGHT_PASS with occupancy 3 via STOP, incl. saturation
        ent = 1'b1;
        wait_then_right("t6", 2);
        ex = 1'b1;
        pw_bad();
        step();
        chk("t6_stop_inc", 1'b0, 1'b0, GS, GP, 3, 1'b0);
        ex = 1'b0;
        pw_ok();
        step();
        chk("t6_right3", 1'b1, 1'b0, GG, GO, 3, 1'b0);
        ex = 1'b1;
        pw_bad();
        step();
        chk("t6_stop_sat", 1'b0, 1'b0, GS, GP, 3, 1'b0);
        ex = 1'b0;
        pw_ok();
        step();
        chk("t6_right_sat", 1'b1, 1'b0, GG, GO, 3, 1'b0);

        // T6: asynchronous reset between clock edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset", 1'b0, 1'b0, BL, BL, 0, 1'b0);
        ent = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("t6_after_reset", 1'b0, 1'b0, BL, BL, 0, 1'b0);

        // Departure with an empty lot saturates at zero
        dep = 1'b1;
        step();
        chk("depart_sat0", 1'b0, 1'b0, BL, BL, 0, 1'b0);
        dep = 1'b0;
        step();
        chk("depart_sat0_hold", 1'b0, 1'b0, BL, BL, 0, 1'b0);

`ifdef LOCKOUT_EN
        // T5: third wrong verdict locks the gate for 16 cycles
        ent = 1'b1;
        p1 = 2'b11;
        p2 = 2'b11;
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 4; i++) begin
                step();
                chk("t5_wait", 1'b0, 1'b1, GE, GN, 0, 1'b0);
            end
            if (t < 2) begin
                for (int i = 0; i < 4; i++) begin
                    step();
                    chk("t5_wrong", 1'b0, 1'(i % 2), GE, GE, 0, 1'b0);
                end
            end
        end
        step();
        chk("t5_locked", 1'b0, 1'b1, GL, GLO, 0, 1'b1);
        ent = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("t5_locked_hold", 1'b0, 1'b1, GL, GLO, 0, 1'b1);
        end
        step();
        chk("t5_unlock_idle", 1'b0, 1'b0, BL, BL, 0, 1'b0);
`endif

        step();
        step();
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
